// File: rtl/health_tracker.sv
// Per-player hit-point tracker: qualifies hits on frame ticks, runs an
// invulnerability countdown after each accepted hit, and latches KO at zero.
module health_tracker #(
  parameter int unsigned MAX_HP        = 100,
  parameter int unsigned DAMAGE        = 10,
  parameter int unsigned INVULN_FRAMES = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       contact,
  input  logic       hit_enable,
  input  logic       round_start,
  output logic [6:0] hp,
  output logic       hit_pulse,
  output logic       invuln,
  output logic       ko
);

  localparam int unsigned HP_W  = 7;
  localparam int unsigned CNT_W = 6;

  typedef enum logic [1:0] {
    ALIVE  = 2'd0,
    INVULN = 2'd1,
    KO     = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [HP_W-1:0]   hp_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic              pulse_nxt;
  logic              frame_prev;
  logic              frame_tick;

  // frame_prev resets high so a frame_clk already high at reset is not a tick
  assign frame_tick = frame_clk & ~frame_prev;

  // State and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      frame_prev <= 1'b1;
      state      <= ALIVE;
      hp         <= HP_W'(MAX_HP);
      cnt        <= '0;
      hit_pulse  <= 1'b0;
      invuln     <= 1'b0;
      ko         <= 1'b0;
    end else begin
      frame_prev <= frame_clk;
      state      <= state_nxt;
      hp         <= hp_nxt;
      cnt        <= cnt_nxt;
      hit_pulse  <= pulse_nxt;
      invuln     <= (state_nxt == INVULN);
      ko         <= (state_nxt == KO);
    end
  end

  // Next-state: round_start wins over anything a tick would do
  always_comb begin
    state_nxt = state;
    hp_nxt    = hp;
    cnt_nxt   = cnt;
    pulse_nxt = 1'b0;

    if (round_start) begin
      state_nxt = ALIVE;
      hp_nxt    = HP_W'(MAX_HP);
      cnt_nxt   = '0;
    end else if (frame_tick) begin
      case (state)
        ALIVE: begin
          if (contact && hit_enable) begin
            pulse_nxt = 1'b1;
            if (hp > HP_W'(DAMAGE)) begin
              hp_nxt    = hp - HP_W'(DAMAGE);
              cnt_nxt   = CNT_W'(INVULN_FRAMES);
              state_nxt = INVULN;
            end else begin
              hp_nxt    = '0;
              cnt_nxt   = '0;
              state_nxt = KO;
            end
          end
        end
        INVULN: begin
          // Expiry tick itself cannot take a hit
          if (cnt <= CNT_W'(1)) begin
            cnt_nxt   = '0;
            state_nxt = ALIVE;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        KO: begin
          hp_nxt = '0;
        end
        default: begin
          state_nxt = ALIVE;
          cnt_nxt   = '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_health_tracker.sv
// Bench for health_tracker: two instances (default and a short 25-HP variant)
// driven in lockstep and compared every cycle against a behavioural model.
module tb_health_tracker;

  logic       Clk = 1'b0;
  logic       Reset, frame_clk, contact, hit_enable, round_start;
  logic [6:0] hp_a, hp_b;
  logic       pulse_a, pulse_b, inv_a, inv_b, ko_a, ko_b;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;
  int tick_no = 0;

  int unsigned P_MAX [2] = '{100, 25};
  int unsigned P_DMG [2] = '{10, 10};
  int unsigned P_INV [2] = '{30, 4};

  // Model: hp, immune ticks remaining, KO flag, last frame_clk, hit pulse
  int m_hp    [2];
  int m_imm   [2];
  bit m_ko    [2];
  bit m_pulse [2];
  bit m_fprev [2];

  always #5 Clk = ~Clk;

  health_tracker u_a (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .contact(contact),
    .hit_enable(hit_enable), .round_start(round_start),
    .hp(hp_a), .hit_pulse(pulse_a), .invuln(inv_a), .ko(ko_a)
  );

  health_tracker #(.MAX_HP(25), .DAMAGE(10), .INVULN_FRAMES(4)) u_b (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .contact(contact),
    .hit_enable(hit_enable), .round_start(round_start),
    .hp(hp_b), .hit_pulse(pulse_b), .invuln(inv_b), .ko(ko_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_step(input bit r, input bit fc, input bit c,
                                     input bit he, input bit rs);
    for (int i = 0; i < 2; i++) begin
      bit tick;
      tick = fc && !m_fprev[i];
      if (r) begin
        m_hp[i] = int'(P_MAX[i]); m_imm[i] = 0; m_ko[i] = 0;
        m_pulse[i] = 0; m_fprev[i] = 1;
      end else begin
        m_fprev[i] = fc;
        m_pulse[i] = 0;
        if (rs) begin
          m_hp[i] = int'(P_MAX[i]); m_imm[i] = 0; m_ko[i] = 0;
        end else if (tick && !m_ko[i]) begin
          if (m_imm[i] > 0) m_imm[i]--;
          else if (c && he) begin
            m_pulse[i] = 1;
            if (m_hp[i] > int'(P_DMG[i])) begin
              m_hp[i] -= int'(P_DMG[i]);
              m_imm[i] = int'(P_INV[i]);
            end else begin
              m_hp[i] = 0;
              m_ko[i] = 1;
            end
          end
        end
      end
    end
  endfunction

  // Per-cycle comparison against the model
  always @(negedge Clk) begin
    if (chk_en) begin
      check("a_hp",     32'(hp_a),    32'(m_hp[0]));
      check("a_pulse",  32'(pulse_a), 32'(m_pulse[0]));
      check("a_invuln", 32'(inv_a),   32'(m_imm[0] > 0));
      check("a_ko",     32'(ko_a),    32'(m_ko[0]));
      check("b_hp",     32'(hp_b),    32'(m_hp[1]));
      check("b_pulse",  32'(pulse_b), 32'(m_pulse[1]));
      check("b_invuln", 32'(inv_b),   32'(m_imm[1] > 0));
      check("b_ko",     32'(ko_b),    32'(m_ko[1]));
    end
  end

  task automatic step(input bit r, input bit fc, input bit c, input bit he, input bit rs);
    Reset = r; frame_clk = fc; contact = c; hit_enable = he; round_start = rs;
    model_step(r, fc, c, he, rs);
    @(negedge Clk);
    #1;
  endtask

  // One frame: a low cycle with noise on contact, then the tick cycle
  task automatic frame(input bit c, input bit he, input bit rs);
    step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
    step(1'b0, 1'b1, c, he, rs);
    tick_no++;
  endtask

  initial begin
    int hits, bhits, last;
    bit fc_r;
    chk_en = 1'b1;

    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    check("rst_hp",     32'(hp_a),    32'd100);
    check("rst_invuln", 32'(inv_a),   32'd0);
    check("rst_ko",     32'(ko_a),    32'd0);
    check("rst_pulse",  32'(pulse_a), 32'd0);
    check("rst_hp_b",   32'(hp_b),    32'd25);

    // frame_clk high coming out of reset is not a tick
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("no_tick_after_rst", 32'(hp_a), 32'd100);

    frame(1'b1, 1'b1, 1'b0);
    check("hit1_hp",     32'(hp_a),    32'd90);
    check("hit1_pulse",  32'(pulse_a), 32'd1);
    check("hit1_invuln", 32'(inv_a),   32'd1);
    check("hit1_hp_b",   32'(hp_b),    32'd15);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("hit1_pulse_off", 32'(pulse_a), 32'd0);

    // Contact held continuously: hits on a exactly 31 ticks apart
    hits = 0; bhits = 0; last = tick_no;
    for (int k = 0; k < 200 && hits < 2; k++) begin
      frame(1'b1, 1'b1, 1'b0);
      if (pulse_a) begin
        hits++;
        check("hit_gap", 32'(tick_no - last), 32'd31);
        last = tick_no;
      end
      if (pulse_b) bhits++;
    end
    check("hits_a_seen", 32'(hits),  32'd2);
    check("hold_hp",     32'(hp_a),  32'd70);
    check("sat_hits_b",  32'(bhits), 32'd2);
    check("sat_hp_b",    32'(hp_b),  32'd0);
    check("sat_ko_b",    32'(ko_b),  32'd1);

    // Let immunity expire, then unqualified contact
    for (int k = 0; k < 31; k++) frame(1'b0, 1'b1, 1'b0);
    check("expired_invuln", 32'(inv_a), 32'd0);
    for (int k = 0; k < 3; k++) frame(1'b1, 1'b0, 1'b0);
    check("no_enable_hp", 32'(hp_a), 32'd70);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("between_ticks_hp", 32'(hp_a), 32'd70);

    // Drive a down to 10, then round_start on the tick of a lethal hit
    for (int k = 0; k < 400 && hp_a != 7'd10; k++) frame(1'b1, 1'b1, 1'b0);
    check("reach_hp10", 32'(hp_a), 32'd10);
    for (int k = 0; k < 30; k++) frame(1'b0, 1'b0, 1'b0);
    frame(1'b1, 1'b1, 1'b1);
    check("rs_hit_hp",    32'(hp_a),    32'd100);
    check("rs_hit_ko",    32'(ko_a),    32'd0);
    check("rs_hit_pulse", 32'(pulse_a), 32'd0);
    check("rs_hp_b",      32'(hp_b),    32'd25);

    // Reset in INVULN with frame_clk held high
    frame(1'b1, 1'b1, 1'b0);
    check("pre_rst_hp", 32'(hp_a), 32'd90);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    check("mid_rst_hp",     32'(hp_a),  32'd100);
    check("mid_rst_invuln", 32'(inv_a), 32'd0);
    frame(1'b1, 1'b1, 1'b0);
    check("post_rst_hit", 32'(hp_a), 32'd90);

    // Randomized traffic
    fc_r = 1'b0;
    for (int k = 0; k < 4000; k++) begin
      if ($urandom_range(0, 2) == 0) fc_r = ~fc_r;
      step(($urandom_range(0, 599) == 0), fc_r,
           1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
           ($urandom_range(0, 149) == 0));
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/health_tracker.md
HEALTH_TRACKER -- requirements
Module: health_tracker

Interface
REQ-001 SHALL have parameter MAX_HP, default 100, starting hit points per round (1..127).
REQ-002 SHALL have parameter DAMAGE, default 10, hit points removed per accepted hit (1..127).
REQ-003 SHALL have parameter INVULN_FRAMES, default 30, frames of immunity after an accepted hit (1..63).
REQ-004 SHALL have port Clk, input, 1, system clock; the block has one clock.
REQ-005 SHALL have port Reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have port frame_clk, input, 1, frame-rate strobe synchronous to Clk; each rising edge is one frame.
REQ-007 SHALL have port contact, input, 1, combinational overlap flag from the hitbox stage.
REQ-008 SHALL have port hit_enable, input, 1, high while the opponent's attack is active.
REQ-009 SHALL have port round_start, input, 1, one-cycle pulse that restarts the round.
REQ-010 SHALL have port hp, output, 7, current hit points, unsigned.
REQ-011 SHALL have port hit_pulse, output, 1, one-Clk pulse per accepted hit.
REQ-012 SHALL have port invuln, output, 1, high while in state INVULN.
REQ-013 SHALL have port ko, output, 1, high while in state KO.

Function
REQ-014 SHALL define frame_tick = frame_clk AND NOT frame_prev, where frame_prev is frame_clk registered on Clk.
REQ-015 SHALL sample contact and hit_enable only in cycles where frame_tick is 1.
REQ-016 SHALL implement the states ALIVE, INVULN and KO; all outputs are registered.
REQ-017 SHALL accept a hit in ALIVE when frame_tick & contact & hit_enable are all 1 in the same cycle.
REQ-018 SHALL, on an accepted hit with hp > DAMAGE: hp <= hp - DAMAGE; load frame counter with INVULN_FRAMES; go to INVULN.
REQ-019 SHALL, on an accepted hit with hp <= DAMAGE: hp <= 0 (saturating, no wrap); go to KO.
REQ-020 SHALL assert hit_pulse for exactly one Clk cycle, at the edge where hp updates, on every accepted hit, including the one that causes KO.
REQ-021 SHALL make hp, state and hit_pulse visible one Clk cycle after the frame_tick cycle (latency 1).
REQ-022 SHALL, in INVULN, ignore contact and hit_enable.
REQ-023 SHALL, in INVULN, decrement the frame counter on each frame_tick.
REQ-024 SHALL, in INVULN, return to ALIVE on the frame_tick where the counter equals 1, so invuln lasts exactly INVULN_FRAMES ticks.
REQ-025 SHALL not accept a hit on the same frame_tick that exits INVULN; the earliest new hit is the next tick.
REQ-026 SHALL keep KO sticky, with hp = 0 and no hit_pulse, until round_start or Reset.
REQ-027 SHALL, on round_start in any state: hp <= MAX_HP, counter <= 0, state <= ALIVE, hit_pulse <= 0.
REQ-028 SHALL give round_start priority over a simultaneous accepted hit or invuln expiry.
REQ-029 SHALL never change hp or state in cycles without frame_tick, except on round_start or Reset.

Reset
REQ-030 SHALL set, on Reset: hp = MAX_HP, state = ALIVE, counter = 0, hit_pulse = 0, invuln = 0, ko = 0.
REQ-031 SHALL reset frame_prev to 1, so no frame_tick occurs until frame_clk is seen low and then high.
REQ-032 SHALL give Reset priority over round_start and all other inputs.
REQ-033 SHALL, on Reset mid-INVULN or in KO, abandon the immunity or KO with no residual countdown.

Verification
REQ-034 SHALL cover the single hit case: defaults, contact=hit_enable=1 on one tick -> next cycle hp=90, hit_pulse=1 for one cycle, invuln=1.
REQ-035 SHALL cover the immunity window: contact held high continuously -> hp steps 100, 90, 80 with accepted hits exactly 31 ticks apart (30 immune ticks plus 1), never faster.
REQ-036 SHALL cover saturation: MAX_HP=25, DAMAGE=10, repeated hits -> hp 15, 5, then 0 with ko=1; further contact -> hp stays 0, no hit_pulse.
REQ-037 SHALL cover qualification: contact=1 with hit_enable=0, or contact pulsed between ticks -> hp unchanged, no hit_pulse.
REQ-038 SHALL cover a simultaneous event: round_start in the same cycle as an accepted hit while hp=10 -> hp=100, ALIVE, ko=0, no hit_pulse.
REQ-039 SHALL cover reset mid-operation: Reset asserted during INVULN with frame_clk held high -> hp=100, invuln=0, and no hit accepted until frame_clk goes low then high again.
